// File: rtl/ooo_pkg.sv
// Shared OoO engine types: logical-op encodings, reservation-station entry layout
// and the CDB wakeup helper used by dispatch capture and in-queue wakeup alike.
package ooo_pkg;

    localparam int TAG_W   = 6;
    localparam int RS_XLEN = 32;

    localparam logic [2:0] LOGIC_XOR = 3'b100;
    localparam logic [2:0] LOGIC_OR  = 3'b110;
    localparam logic [2:0] LOGIC_AND = 3'b111;

    typedef struct packed {
        logic [RS_XLEN-1:0] val;
        logic               rdy;
        logic [TAG_W-1:0]   tag;
    } rs_src_t;

    typedef struct packed {
        logic             valid;
        logic [2:0]       op;
        rs_src_t          src1;
        rs_src_t          src2;
        logic [TAG_W-1:0] dest_tag;
    } rs_entry_t;

    // A pending source grabs the broadcast value when its producer tag is on the CDB.
    function automatic rs_src_t src_wake(input rs_src_t s, input logic cdb_v,
                                         input logic [TAG_W-1:0] cdb_t,
                                         input logic [RS_XLEN-1:0] cdb_d);
        src_wake = s;
        if (cdb_v && !s.rdy && s.tag == cdb_t) begin
            src_wake.val = cdb_d;
            src_wake.rdy = 1'b1;
        end
    endfunction

endpackage

// File: rtl/logical_rs_select.sv
// Lowest-index-ready priority picker: one-hot grant of the oldest ready slot plus found flag.
module logical_rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] grant_o,
    output logic             found_o
);

    // Isolate the lowest set bit; slot 0 is the oldest entry.
    assign grant_o = req_i & (~req_i + DEPTH'(1));
    assign found_o = |req_i;

endmodule

// File: rtl/logical_rs.sv
// Reservation station for the logical FU: compacting age queue with CDB wakeup and oldest-ready issue.
// Optional LOGICAL_RS_PERF_EN adds saturating full/stall cycle counters.
module logical_rs #(
    parameter int XLEN  = ooo_pkg::RS_XLEN,
    parameter int DEPTH = 4,
    parameter int TAG_W = ooo_pkg::TAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [2:0]                 disp_op,
    input  logic [XLEN-1:0]            disp_rs1_val,
    input  logic                       disp_rs1_rdy,
    input  logic [TAG_W-1:0]           disp_rs1_tag,
    input  logic [XLEN-1:0]            disp_rs2_val,
    input  logic                       disp_rs2_rdy,
    input  logic [TAG_W-1:0]           disp_rs2_tag,
    input  logic [TAG_W-1:0]           disp_dest_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [XLEN-1:0]            cdb_data,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [2:0]                 iss_op,
    output logic [XLEN-1:0]            iss_rs1,
    output logic [XLEN-1:0]            iss_rs2,
    output logic [TAG_W-1:0]           iss_dest_tag,
`ifdef LOGICAL_RS_PERF_EN
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [31:0]                perf_full_cycles,
    output logic [31:0]                perf_stall_cycles
`else
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);
    import ooo_pkg::*;

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    rs_entry_t        woke  [DEPTH+1];
    rs_entry_t        new_ent;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [DEPTH-1:0] rdy_vec, grant;
    logic             found;
    logic [IDX_W-1:0] sel_idx;
    logic             disp_fire, iss_fire;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            rdy_vec[i] = ent_q[i].valid && ent_q[i].src1.rdy && ent_q[i].src2.rdy;
    end

    logical_rs_select #(.DEPTH(DEPTH)) u_sel (
        .req_i   (rdy_vec),
        .grant_o (grant),
        .found_o (found)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (grant[i]) sel_idx = IDX_W'(i);
    end

    assign disp_ready   = occ_q < OCC_W'(DEPTH);
    assign disp_fire    = disp_valid && disp_ready;
    assign iss_valid    = found;
    assign iss_fire     = found && iss_ready;
    assign iss_op       = ent_q[sel_idx].op;
    assign iss_rs1      = ent_q[sel_idx].src1.val;
    assign iss_rs2      = ent_q[sel_idx].src2.val;
    assign iss_dest_tag = ent_q[sel_idx].dest_tag;
    assign occupancy    = occ_q;

    always_comb begin
        new_ent               = '0;
        new_ent.valid         = 1'b1;
        new_ent.op            = disp_op;
        new_ent.src1.val      = disp_rs1_val;
        new_ent.src1.rdy      = disp_rs1_rdy;
        new_ent.src1.tag      = disp_rs1_tag;
        new_ent.src2.val      = disp_rs2_val;
        new_ent.src2.rdy      = disp_rs2_rdy;
        new_ent.src2.tag      = disp_rs2_tag;
        new_ent.dest_tag      = disp_dest_tag;
        new_ent.src1          = src_wake(new_ent.src1, cdb_valid, cdb_tag, cdb_data);
        new_ent.src2          = src_wake(new_ent.src2, cdb_valid, cdb_tag, cdb_data);
    end

    // Extra top slot stays empty so the shift-down reads a clean entry into the last slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i]      = ent_q[i];
            woke[i].src1 = src_wake(ent_q[i].src1, cdb_valid && ent_q[i].valid, cdb_tag, cdb_data);
            woke[i].src2 = src_wake(ent_q[i].src2, cdb_valid && ent_q[i].valid, cdb_tag, cdb_data);
        end
        woke[DEPTH] = '0;
    end

    always_comb begin
        occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(iss_fire);
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_fire && IDX_W'(i) >= sel_idx)
                ent_d[i] = woke[i+1];
            else
                ent_d[i] = woke[i];
            if (disp_fire && OCC_W'(i) == occ_q - OCC_W'(iss_fire))
                ent_d[i] = new_ent;
        end
        if (flush) begin
            occ_d = '0;
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            occ_q <= occ_d;
            ent_q <= ent_d;
        end
    end

`ifdef LOGICAL_RS_PERF_EN
    logic [31:0] perf_full_q, perf_stall_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (occ_q == OCC_W'(DEPTH) && ~&perf_full_q)
                perf_full_q <= perf_full_q + 32'd1;
            if (found && !iss_ready && ~&perf_stall_q)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_full_cycles  = perf_full_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_logical_rs.sv
// Directed bench for logical_rs: queue-based reference model checked every cycle plus literal spot checks.
module tb_logical_rs;
    import ooo_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        disp_valid, disp_ready;
    logic [2:0]  disp_op;
    logic [31:0] disp_rs1_val, disp_rs2_val;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    logic [5:0]  disp_rs1_tag, disp_rs2_tag, disp_dest_tag;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        iss_valid, iss_ready;
    logic [2:0]  iss_op;
    logic [31:0] iss_rs1, iss_rs2;
    logic [5:0]  iss_dest_tag;
    logic [2:0]  occupancy;
`ifdef LOGICAL_RS_PERF_EN
    logic [31:0] perf_full_cycles, perf_stall_cycles;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    logical_rs dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_rs1_val(disp_rs1_val), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag),
        .disp_rs2_val(disp_rs2_val), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag),
        .disp_dest_tag(disp_dest_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_dest_tag(iss_dest_tag),
`ifdef LOGICAL_RS_PERF_EN
        .occupancy(occupancy),
        .perf_full_cycles(perf_full_cycles),
        .perf_stall_cycles(perf_stall_cycles)
`else
        .occupancy(occupancy)
`endif
    );

    // Reference model: a plain age-ordered list of pending ops.
    typedef struct {
        logic [2:0]  op;
        logic [31:0] v1;
        bit          r1;
        logic [5:0]  t1;
        logic [31:0] v2;
        bit          r2;
        logic [5:0]  t2;
        logic [5:0]  dest;
    } m_t;
    m_t q[$];

    function automatic int model_sel();
        for (int i = 0; i < q.size(); i++)
            if (q[i].r1 && q[i].r2) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        int  s;
        bit  dfire;
        m_t  n;
        if (rst || flush) begin
            q.delete();
        end else begin
            s     = model_sel();
            dfire = disp_valid && (q.size() < 4);
            for (int i = 0; i < q.size(); i++) begin
                if (cdb_valid && !q[i].r1 && q[i].t1 == cdb_tag) begin q[i].v1 = cdb_data; q[i].r1 = 1; end
                if (cdb_valid && !q[i].r2 && q[i].t2 == cdb_tag) begin q[i].v2 = cdb_data; q[i].r2 = 1; end
            end
            if (s >= 0 && iss_ready) q.delete(s);
            if (dfire) begin
                n.op = disp_op; n.dest = disp_dest_tag;
                n.v1 = disp_rs1_val; n.r1 = disp_rs1_rdy; n.t1 = disp_rs1_tag;
                n.v2 = disp_rs2_val; n.r2 = disp_rs2_rdy; n.t2 = disp_rs2_tag;
                if (cdb_valid && !n.r1 && n.t1 == cdb_tag) begin n.v1 = cdb_data; n.r1 = 1; end
                if (cdb_valid && !n.r2 && n.t2 == cdb_tag) begin n.v2 = cdb_data; n.r2 = 1; end
                q.push_back(n);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int s;
        if (!rst) begin
            s = model_sel();
            check("occupancy", 32'(occupancy), q.size());
            check("disp_ready", 32'(disp_ready), 32'(q.size() < 4));
            check("iss_valid", 32'(iss_valid), 32'(s >= 0));
            if (s >= 0) begin
                check("iss_op", 32'(iss_op), 32'(q[s].op));
                check("iss_rs1", iss_rs1, q[s].v1);
                check("iss_rs2", iss_rs2, q[s].v2);
                check("iss_dest_tag", 32'(iss_dest_tag), 32'(q[s].dest));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 0; cdb_valid = 0; flush = 0;
        disp_rs1_rdy = 0; disp_rs2_rdy = 0;
    endtask

    task automatic disp(input logic [2:0] op, input logic [31:0] v1, input bit r1, input logic [5:0] t1,
                        input logic [31:0] v2, input bit r2, input logic [5:0] t2, input logic [5:0] dest);
        disp_valid = 1; disp_op = op; disp_dest_tag = dest;
        disp_rs1_val = v1; disp_rs1_rdy = r1; disp_rs1_tag = t1;
        disp_rs2_val = v2; disp_rs2_rdy = r2; disp_rs2_tag = t2;
    endtask

    task automatic cdb(input logic [5:0] t, input logic [31:0] d);
        cdb_valid = 1; cdb_tag = t; cdb_data = d;
    endtask

    initial begin
        rst = 1; iss_ready = 0;
        idle();
        disp_op = 0; disp_rs1_val = 0; disp_rs2_val = 0; disp_rs1_tag = 0; disp_rs2_tag = 0;
        disp_dest_tag = 0; cdb_tag = 0; cdb_data = 0;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        check("reset occupancy", 32'(occupancy), 0);
        check("reset disp_ready", 32'(disp_ready), 1);
        check("reset iss_valid", 32'(iss_valid), 0);

        // OR, both sources ready
        disp(LOGIC_OR, 32'h0F0F0000, 1, 0, 32'h000000FF, 1, 0, 5);
        tick(); idle();
        @(negedge clk);
        check("or iss_valid", 32'(iss_valid), 1);
        check("or iss_op", 32'(iss_op), 32'h6);
        check("or iss_rs1", iss_rs1, 32'h0F0F0000);
        check("or iss_rs2", iss_rs2, 32'h000000FF);
        check("or dest", 32'(iss_dest_tag), 5);
        iss_ready = 1;
        tick(); iss_ready = 0;
        @(negedge clk);
        check("or drained occ", 32'(occupancy), 0);

        // AND waiting on tag 9
        disp(LOGIC_AND, 0, 0, 9, 32'hFFFF, 1, 0, 1);
        tick(); idle();
        @(negedge clk);
        check("and waiting iss_valid", 32'(iss_valid), 0);
        cdb(9, 32'h1234);
        tick(); idle();
        @(negedge clk);
        check("and woken iss_valid", 32'(iss_valid), 1);
        check("and woken rs1", iss_rs1, 32'h1234);
        iss_ready = 1; tick(); iss_ready = 0;

        // dispatch-cycle CDB capture
        disp(LOGIC_XOR, 32'h11, 1, 0, 0, 0, 3, 2);
        cdb(3, 32'hA5);
        tick(); idle();
        @(negedge clk);
        check("capture iss_valid", 32'(iss_valid), 1);
        check("capture rs2", iss_rs2, 32'hA5);
        iss_ready = 1; tick(); iss_ready = 0;

        // fill, then issue with a blocked dispatch
        for (int i = 0; i < 4; i++) begin
            disp(LOGIC_XOR, 32'h100 + i, 1, 0, 32'h200 + i, 1, 0, 6'(10 + i));
            tick();
        end
        idle();
        @(negedge clk);
        check("full disp_ready", 32'(disp_ready), 0);
        check("full occ", 32'(occupancy), 4);
        check("full head dest", 32'(iss_dest_tag), 10);
        iss_ready = 1;
        disp(LOGIC_OR, 32'h300, 1, 0, 32'h301, 1, 0, 14);
        tick(); iss_ready = 0;
        @(negedge clk);
        check("blocked disp occ", 32'(occupancy), 3);
        tick(); idle();
        @(negedge clk);
        check("late disp occ", 32'(occupancy), 4);
        check("after issue head dest", 32'(iss_dest_tag), 11);
        iss_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        iss_ready = 0;
        @(negedge clk);
        check("drain occ", 32'(occupancy), 0);

        // younger ready op bypasses older waiting op
        iss_ready = 1;
        disp(LOGIC_XOR, 0, 0, 7, 32'h55, 1, 0, 20);
        tick();
        disp(LOGIC_OR, 32'h1, 1, 0, 32'h2, 1, 0, 21);
        tick(); idle();
        @(negedge clk);
        check("bypass dest", 32'(iss_dest_tag), 21);
        tick();
        cdb(7, 32'h77);
        tick(); idle();
        @(negedge clk);
        check("woken older dest", 32'(iss_dest_tag), 20);
        check("woken older rs1", iss_rs1, 32'h77);
        tick();
        iss_ready = 0;
        disp(LOGIC_AND, 0, 0, 8, 32'h3, 1, 0, 22);
        tick();
        disp(LOGIC_OR, 0, 0, 8, 32'h4, 1, 0, 23);
        tick(); idle();
        cdb(8, 32'h88);
        tick(); idle();
        @(negedge clk);
        check("age order first", 32'(iss_dest_tag), 22);
        check("age order occ", 32'(occupancy), 2);
        iss_ready = 1;
        tick();
        @(negedge clk);
        check("age order second", 32'(iss_dest_tag), 23);
        tick(); iss_ready = 0;

        // unknown op passes through; one tag wakes both sources
        disp(3'b011, 32'h1, 1, 0, 32'h2, 1, 0, 40);
        tick(); idle();
        @(negedge clk);
        check("odd op", 32'(iss_op), 32'h3);
        iss_ready = 1; tick(); iss_ready = 0;
        disp(LOGIC_AND, 0, 0, 12, 0, 0, 12, 41);
        tick(); idle();
        cdb(12, 32'h5);
        tick(); idle();
        @(negedge clk);
        check("dual wake rs1", iss_rs1, 32'h5);
        check("dual wake rs2", iss_rs2, 32'h5);
        iss_ready = 1; tick(); iss_ready = 0;

        // flush beats dispatch and CDB
        disp(LOGIC_XOR, 32'h9, 1, 0, 32'h9, 1, 0, 30);
        tick();
        disp(LOGIC_OR, 0, 0, 15, 32'h9, 1, 0, 31);
        tick();
        disp(LOGIC_AND, 32'h9, 1, 0, 32'h9, 1, 0, 32);
        tick();
        disp(LOGIC_XOR, 32'hA, 1, 0, 32'hB, 1, 0, 33);
        flush = 1;
        cdb(15, 32'hC);
        @(negedge clk);
        check("pre-flush occ", 32'(occupancy), 3);
        tick(); idle();
        @(negedge clk);
        check("flush occ", 32'(occupancy), 0);
        check("flush iss_valid", 32'(iss_valid), 0);
        tick();
        @(negedge clk);
        check("flush dropped disp", 32'(occupancy), 0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/logical_rs.md
Name: logical_rs

Overview:
Reservation station in front of the logical functional unit in the OoO engine. It accepts dispatched XOR/OR/AND micro-ops, holds them until both source operands are available, and snoops the common data bus (CDB) to wake up pending operands. Each cycle it issues the oldest ready entry to the logical FU through a valid/ready handshake, so it is the producer side of the FU's operand interface.

Parameters:
XLEN, 32, operand/result data width
DEPTH, 4, number of RS entries (>=2)
TAG_W, 6, ROB tag width used for source and destination tags

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
flush  input  1  pipeline flush; drops all entries
disp_valid  input  1  dispatch request
disp_ready  output  1  RS can accept a dispatch this cycle
disp_op  input  3  logical_type: 3'b100 XOR, 3'b110 OR, 3'b111 AND
disp_rs1_val  input  XLEN  src1 value (valid when disp_rs1_rdy)
disp_rs1_rdy  input  1  src1 already available
disp_rs1_tag  input  TAG_W  src1 producer tag (when not ready)
disp_rs2_val / disp_rs2_rdy / disp_rs2_tag  input  XLEN/1/TAG_W  same, for src2
disp_dest_tag  input  TAG_W  destination ROB tag
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_W  CDB broadcast tag
cdb_data  input  XLEN  CDB broadcast value
iss_valid  output  1  issue request to FU
iss_ready  input  1  FU accepts the issue
iss_op  output  3  logical_type to FU
iss_rs1  output  XLEN  src1 operand
iss_rs2  output  XLEN  src2 operand
iss_dest_tag  output  TAG_W  destination tag travelling with the op
occupancy  output  clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset and flush (synchronous): all entries invalid; occupancy=0; disp_ready=1; iss_valid=0. Other iss_* outputs are don't-care while iss_valid=0. Flush takes priority over a same-cycle dispatch, issue, and CDB update; the dispatch is dropped.
- Storage is a compacting age queue. Slots 0..occupancy-1 are valid, and slot 0 is the oldest. Each entry holds op, rs1/rs2 value+rdy+tag, and dest_tag.
- disp_ready = (occupancy < DEPTH), based only on current state. A slot freed by an issue in the same cycle is not usable until the next cycle.
- Dispatch fires when disp_valid && disp_ready. The new entry is written at slot occupancy, or slot occupancy-1 if an issue fires in the same cycle.
- Dispatch/CDB same-cycle capture: if cdb_valid, a source is not ready, and its tag equals cdb_tag, the entry stores cdb_data with rdy=1.
- Wakeup: every valid entry compares each non-ready source tag to cdb_tag when cdb_valid. On a match it latches cdb_data and sets rdy at the clock edge. Both sources may wake in the same cycle.
- Issue selection is combinational from registered state: the lowest-index entry with both sources rdy. iss_valid=1 if such an entry exists.
- Issue latency: an op dispatched fully ready in cycle N can issue in cycle N+1. An op woken by the CDB in cycle N can issue in N+1. There is no same-cycle CDB-to-issue bypass.
- Issue fires when iss_valid && iss_ready. The selected entry is removed, and entries above it shift down by one, preserving order.
- Issue outputs hold stable while iss_valid && !iss_ready, unless an older entry becomes ready. Re-selecting the older entry is legal.
- Ops outside the three encodings are accepted and issued unchanged; the FU produces 0 for them.
- occupancy changes as +1 for dispatch, -1 for issue, 0 for both, and goes to 0 on flush or reset.

Optional Feature:
LOGICAL_RS_PERF_EN
- Defined: adds output perf_full_cycles [31:0] and output perf_stall_cycles [31:0].
  - perf_full_cycles counts cycles with occupancy==DEPTH.
  - perf_stall_cycles counts cycles with iss_valid && !iss_ready.
  - Both counters saturate at 32'hFFFF_FFFF, clear on rst, and are not cleared by flush.
- Undefined: neither port nor the counter logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package ooo_pkg:
  - LOGIC_XOR=3'b100, LOGIC_OR=3'b110, LOGIC_AND=3'b111;
  - TAG_W default;
  - rs_entry_t struct (valid, op, src1/src2 {val, rdy, tag}, dest_tag).
- One sub-module, logical_rs_select: a DEPTH-wide lowest-index-ready priority picker that outputs a one-hot grant plus a found flag. The shift/compaction logic stays in logical_rs.

Test Plan:
- Dispatch OR with rs1=0x0F0F0000 (rdy), rs2=0x000000FF (rdy), dest=5 -> iss_valid=1 next cycle with iss_op=3'b110, iss_rs1=0x0F0F0000, iss_rs2=0x000000FF, iss_dest_tag=5; the entry leaves on iss_ready and occupancy returns to 0.
- Dispatch AND with rs1 waiting on tag 9 and rs2=0xFFFF (rdy) -> no issue. CDB tag=9 data=0x1234 -> iss_valid the following cycle with iss_rs1=0x1234.
- Dispatch with rs2 waiting on tag 3 while CDB broadcasts tag 3 data=0xA5 in the same cycle -> entry captures 0xA5 and issues next cycle.
- Fill 4 entries with iss_ready=0 -> disp_ready=0 and occupancy=4. Then assert iss_ready=1 with disp_valid=1 -> one issue fires, the dispatch is not accepted that cycle, and it is accepted the next cycle.
- Dispatch A (waiting on tag 7) then B (ready), hold iss_ready=1 -> B issues first. After CDB tag 7, A issues, with older-first order among ready entries verified.
- Flush asserted with 3 valid entries and a concurrent dispatch -> next cycle occupancy=0, iss_valid=0, and the dispatched op is absent.
